// File: rtl/fht_pkg.sv
// Shared FHT definitions: default sizing, loader state encoding and the
// bit-reverse helper used by both the input loader and the coefficient path.
package fht_pkg;

  localparam int FHT_A_BIT_DEF = 8;
  localparam int BANK_SIZE     = 1 << FHT_A_BIT_DEF;
  localparam int FRAME_SIZE    = 4 * BANK_SIZE;

  typedef enum logic [2:0] {
    LOAD,
    FLUSHWR,
    START,
    WAIT_ACK,
    WAIT_DONE
  } fht_state_e;

  // Reverses the low w bits of v; bits at and above w come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < w) r[i] = v[5'(w - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/fht_bitrev_addr.sv
// Maps a natural-order sample index to its stage-0 location: the two low bits
// of the reversed index pick the bank, the remaining bits the bank address.
module fht_bitrev_addr
  import fht_pkg::*;
#(
  parameter int A_BIT = FHT_A_BIT_DEF
) (
  input  logic [A_BIT+1:0] idx_i,
  output logic [1:0]       bank_o,
  output logic [A_BIT-1:0] addr_o
);

  assign {addr_o, bank_o} = (A_BIT+2)'(bitrev(32'(idx_i), A_BIT + 2));

endmodule

// File: rtl/fht_input_loader.sv
// Streams one FHT frame into the 4 RAM banks in bit-reversed order, then kicks
// fht_control and waits for it to finish. Optional input scaling: FHT_LOADER_SCALE_EN.
module fht_input_loader
  import fht_pkg::*;
#(
  parameter int A_BIT = FHT_A_BIT_DEF,
  parameter int D_BIT = 16,
  parameter int SCALE = 2
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic [D_BIT-1:0] iDATA,
  input  logic             iVALID,
  output logic             oREADY,
  input  logic             iFLUSH,
  input  logic             iFHT_RDY,
  output logic             oSTART,
  output logic [3:0]       oWE,
  output logic [A_BIT-1:0] oADDR_WR,
  output logic [D_BIT-1:0] oDATA_WR,
  output logic             oBUSY,
  output logic [A_BIT+1:0] oCNT
);

`ifdef FHT_LOADER_SCALE_EN
  localparam bit ScaleOn = 1'b1;
`else
  localparam bit ScaleOn = 1'b0;
`endif
  localparam int Shift = ScaleOn ? SCALE : 0;

  fht_state_e       state_q, state_d;
  logic [A_BIT+1:0] cnt_q, cnt_d;
  logic [1:0]       ack_q, ack_d;
  logic [3:0]       we_q, we_d;
  logic [A_BIT-1:0] addr_q, addr_d;
  logic [D_BIT-1:0] data_q, data_d;

  logic             readyS, startS, busyS;
  logic             xfer;
  logic [1:0]       bankSel;
  logic [A_BIT-1:0] bankAddr;
  logic [D_BIT-1:0] sampleIn;

  fht_bitrev_addr #(.A_BIT(A_BIT)) u_bitrev (
    .idx_i  (cnt_q),
    .bank_o (bankSel),
    .addr_o (bankAddr)
  );

  // Round-half-up before the arithmetic shift; one guard bit absorbs the carry.
  generate
    if (Shift > 0) begin : g_scale
      localparam logic signed [D_BIT:0] Half = (D_BIT+1)'(2 ** (Shift - 1));
      logic signed [D_BIT:0] roundSum;
      assign roundSum = {iDATA[D_BIT-1], iDATA} + Half;
      assign sampleIn = D_BIT'(roundSum >>> Shift);
    end else begin : g_noscale
      assign sampleIn = iDATA;
    end
  endgenerate

  // Ready is forced low while reset is held, not just after it releases.
  assign oREADY = readyS & iRESET;
  assign xfer   = iVALID & oREADY & ~iFLUSH;

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      ack_q   <= '0;
      we_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // A start that fht_control does not acknowledge within 4 cycles is retried.
  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    case (state_q)
      LOAD:      if (xfer && (&cnt_q)) state_d = FLUSHWR;
      FLUSHWR:   state_d = START;
      START: begin
        state_d = WAIT_ACK;
        ack_d   = '0;
      end
      WAIT_ACK: begin
        if (!iFHT_RDY)           state_d = WAIT_DONE;
        else if (ack_q == 2'd3)  state_d = START;
        else                     ack_d   = ack_q + 2'd1;
      end
      WAIT_DONE: if (iFHT_RDY) state_d = LOAD;
      default:   state_d = LOAD;
    endcase
  end

  always_comb begin
    readyS = 1'b0;
    startS = 1'b0;
    busyS  = 1'b0;
    case (state_q)
      LOAD:      readyS = 1'b1;
      START: begin
        startS = 1'b1;
        busyS  = 1'b1;
      end
      WAIT_ACK:  busyS = 1'b1;
      WAIT_DONE: busyS = 1'b1;
      default:   ;
    endcase
  end

  // A flush wins over a simultaneous sample; the counter wraps on its own at N-1.
  always_comb begin
    cnt_d  = cnt_q;
    we_d   = '0;
    addr_d = addr_q;
    data_d = data_q;
    if ((state_q == LOAD) && iFLUSH) begin
      cnt_d = '0;
    end else if (xfer) begin
      cnt_d  = cnt_q + (A_BIT+2)'(1);
      we_d   = 4'b0001 << bankSel;
      addr_d = bankAddr;
      data_d = sampleIn;
    end
  end

  assign oSTART   = startS;
  assign oBUSY    = busyS;
  assign oWE      = we_q;
  assign oADDR_WR = addr_q;
  assign oDATA_WR = data_q;
  assign oCNT     = cnt_q;

endmodule
